// File: rtl/spi_flash_pkg.sv
// Shared opcodes, state/source enums and helpers
// for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_ID,
    SRC_STATUS
  } src_e;

  function automatic logic [7:0] id_byte(
    input logic [23:0] id,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      default: b = id[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser with rise/fall detection
// on the synchronised level.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = d_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;
  assign fall  = ~s2_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash slave answering READ, RDID and RDSR,
// prefetching READ data one byte ahead.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4015,
  parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flash_clk,
  input  logic        flash_cs,
  input  logic        flash_di,
  output logic        flash_do,
  output logic        mem_en,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_byte,
  input  logic        mem_vld
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic di_lvl, di_rise, di_fall;
  logic unused_sync;

  spi_in_sync #(.RST_VAL(1'b1)) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .d_in  (flash_clk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_in_sync #(.RST_VAL(1'b1)) u_cs (
    .clk   (clk),
    .rst   (rst),
    .d_in  (flash_cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_in_sync #(.RST_VAL(1'b1)) u_di (
    .clk   (clk),
    .rst   (rst),
    .d_in  (flash_di),
    .level (di_lvl),
    .rise  (di_rise),
    .fall  (di_fall)
  );

  assign unused_sync = &{1'b0, sclk_lvl, cs_rise,
                         di_rise, di_fall};

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [22:0] sh_in_q, sh_in_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        flash_do_q, flash_do_d;
  logic        mem_en_q, mem_en_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        pend_q, pend_d;
  logic        armed_q, armed_d;
  logic [1:0]  flush_q, flush_d;

  logic [23:0] rx_bits;
  logic [7:0]  next_byte;

  assign rx_bits = {sh_in_q, di_lvl};

  always_comb begin
    case (src_q)
      SRC_MEM:  next_byte = hold_vld_q ? hold_q : 8'hFF;
      SRC_ID:   next_byte = id_byte(JEDEC_ID, byte_cnt_q);
      default:  next_byte = STATUS_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_in_d    = sh_in_q;
    tx_sh_d    = tx_sh_q;
    flash_do_d = flash_do_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    pend_d     = pend_q;
    armed_d    = armed_q;
    flush_d    = flush_q;

    // Synchroniser output is only trusted once its reset
    // values have flushed; a cs held low through reset
    // must not look like a fresh select.
    if (flush_q != 2'd2) flush_d = flush_q + 2'd1;
    if (flush_q == 2'd2 && cs_lvl) armed_d = 1'b1;

    if (cs_lvl) begin
      state_d    = ST_IDLE;
      flash_do_d = 1'b1;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      hold_vld_d = 1'b0;
      pend_d     = 1'b0;
    end else begin
      if (state_q != ST_DATA) flash_do_d = 1'b1;
      if (pend_q && mem_vld && state_q == ST_DATA) begin
        hold_d     = mem_byte;
        hold_vld_d = 1'b1;
        pend_d     = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (cs_fall && armed_q) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            sh_in_d = rx_bits[22:0];
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
              case (rx_bits[7:0])
                OP_READ: state_d = ST_ADDR;
                OP_RDID: begin
                  state_d = ST_DATA;
                  src_d   = SRC_ID;
                end
                OP_RDSR: begin
                  state_d = ST_DATA;
                  src_d   = SRC_STATUS;
                end
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            sh_in_d = rx_bits[22:0];
            if (bit_cnt_q == 5'd23) begin
              mem_en_d   = 1'b1;
              mem_addr_d = rx_bits;
              pend_d     = 1'b1;
              hold_vld_d = 1'b0;
              state_d    = ST_DATA;
              src_d      = SRC_MEM;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (sclk_fall) begin
            if (bit_cnt_q == 5'd0) begin
              flash_do_d = next_byte[7];
              tx_sh_d    = {next_byte[6:0], 1'b0};
              bit_cnt_d  = 5'd1;
              if (src_q == SRC_ID)
                byte_cnt_d = (byte_cnt_q == 2'd2) ?
                             2'd0 : byte_cnt_q + 2'd1;
              if (src_q == SRC_MEM) begin
                hold_vld_d = 1'b0;
                if (!pend_q) begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = mem_addr_q + 24'd1;
                  pend_d     = 1'b1;
                end
              end
            end else begin
              flash_do_d = tx_sh_q[7];
              tx_sh_d    = {tx_sh_q[6:0], 1'b0};
              bit_cnt_d  = (bit_cnt_q == 5'd7) ?
                           5'd0 : bit_cnt_q + 5'd1;
            end
          end
        end
        default: flash_do_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_MEM;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sh_in_q    <= '0;
      tx_sh_q    <= '0;
      flash_do_q <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      armed_q    <= 1'b0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_in_q    <= sh_in_d;
      tx_sh_q    <= tx_sh_d;
      flash_do_q <= flash_do_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      pend_q     <= pend_d;
      armed_q    <= armed_d;
      flush_q    <= flush_d;
    end
  end

  assign flash_do = flash_do_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: SPI master tasks plus a memory
// model with random 1-4 cycle fetch latency.
module tb_spi_flash_responder;

  localparam int HP = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flash_clk = 1'b1;
  logic        flash_cs = 1'b1;
  logic        flash_di = 1'b1;
  logic        flash_do;
  logic        mem_en;
  logic [23:0] mem_addr;
  logic [7:0]  mem_byte = 8'h00;
  logic        mem_vld = 1'b0;

  int checks = 0;
  int errors = 0;
  int fetches = 0;

  logic [23:0] exp_addr[$];
  logic [7:0]  exp_rx[$];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk       (clk),
    .rst       (rst),
    .flash_clk (flash_clk),
    .flash_cs  (flash_cs),
    .flash_di  (flash_di),
    .flash_do  (flash_do),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_byte  (mem_byte),
    .mem_vld   (mem_vld)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_at(
    input logic [23:0] a
  );
    return a[7:0] ^ 8'h5A;
  endfunction

  // memory model: answers each fetch after 1-4 cycles
  initial begin
    logic [23:0] a;
    int lat;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en === 1'b1) begin
        fetches++;
        a = mem_addr;
        check("fetch_expected",
              32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0)
          check("fetch_addr", a, exp_addr.pop_front());
        lat = $urandom_range(1, 4);
        repeat (lat - 1) @(posedge clk);
        #1;
        mem_byte = mem_at(a);
        mem_vld  = 1'b1;
        @(posedge clk);
        #1;
        mem_vld  = 1'b0;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin(input bit cpol);
    flash_clk = cpol;
    wait_clk(4);
    flash_cs = 1'b0;
    wait_clk(HP);
  endtask

  task automatic spi_bits(input logic [7:0] tx,
                          input int n,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      flash_clk = 1'b0;
      flash_di  = tx[7-i];
      wait_clk(HP);
      rx = {rx[6:0], flash_do};
      flash_clk = 1'b1;
      wait_clk(HP);
    end
  endtask

  task automatic spi_end(input bit cpol);
    if (!cpol) begin
      flash_clk = 1'b0;
      wait_clk(HP);
    end
    flash_cs = 1'b1;
    wait_clk(3 * HP);
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
  endtask

  task automatic rx_byte(input string tag);
    logic [7:0] rx;
    spi_bits(8'h00, 8, rx);
    check({tag, "_have_exp"},
          32'(exp_rx.size() > 0), 32'd1);
    if (exp_rx.size() > 0)
      check(tag, rx, exp_rx.pop_front());
  endtask

  task automatic cmd_read(input bit cpol,
                          input logic [23:0] a);
    spi_begin(cpol);
    send(8'h03);
    send(a[23:16]);
    send(a[15:8]);
    send(a[7:0]);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [23:0] a;
    int f0;

    wait_clk(3);
    check("rst_do", flash_do, 1);
    check("rst_en", mem_en, 0);
    check("rst_addr", mem_addr, 0);
    rst = 1'b0;
    wait_clk(5);

    // READ, mode 3, from 0x000100
    for (int i = 0; i <= 4; i++)
      exp_addr.push_back(24'h000100 + 24'(i));
    for (int i = 0; i < 4; i++)
      exp_rx.push_back(mem_at(24'h000100 + 24'(i)));
    cmd_read(1'b1, 24'h000100);
    for (int i = 0; i < 4; i++) rx_byte("read_m3");
    spi_end(1'b1);
    check("read_fetch_all", exp_addr.size(), 0);

    // RDID, mode 0
    exp_rx.push_back(8'hEF);
    exp_rx.push_back(8'h40);
    exp_rx.push_back(8'h15);
    exp_rx.push_back(8'hEF);
    spi_begin(1'b0);
    send(8'h9F);
    for (int i = 0; i < 4; i++) rx_byte("rdid");
    spi_end(1'b0);

    // READ wrapping the 24-bit address
    a = 24'hFFFFFF;
    for (int i = 0; i <= 2; i++) begin
      exp_addr.push_back(a);
      if (i < 2) exp_rx.push_back(mem_at(a));
      a = a + 24'd1;
    end
    cmd_read(1'b1, 24'hFFFFFF);
    rx_byte("read_wrap");
    rx_byte("read_wrap");
    spi_end(1'b1);
    check("wrap_fetch_all", exp_addr.size(), 0);

    // unknown opcode, then RDSR
    f0 = fetches;
    exp_rx.push_back(8'hFF);
    exp_rx.push_back(8'hFF);
    spi_begin(1'b0);
    send(8'h55);
    rx_byte("ignore_miso");
    rx_byte("ignore_miso");
    spi_end(1'b0);
    check("ignore_nofetch", fetches, f0);
    exp_rx.push_back(8'h00);
    exp_rx.push_back(8'h00);
    spi_begin(1'b0);
    send(8'h05);
    rx_byte("rdsr");
    rx_byte("rdsr");
    spi_end(1'b0);

    // abort mid-byte, then a fresh READ
    exp_addr.push_back(24'h000020);
    exp_addr.push_back(24'h000021);
    exp_addr.push_back(24'h000022);
    exp_rx.push_back(mem_at(24'h000020));
    cmd_read(1'b0, 24'h000020);
    rx_byte("pre_abort");
    spi_bits(8'h00, 3, rx);
    a = 24'h000021;
    check("partial_bits", rx[2:0], 32'(mem_at(a) >> 5));
    spi_end(1'b0);
    exp_addr.push_back(24'h000010);
    exp_addr.push_back(24'h000011);
    exp_rx.push_back(mem_at(24'h000010));
    cmd_read(1'b1, 24'h000010);
    rx_byte("after_abort");
    spi_end(1'b1);
    check("abort_fetch_all", exp_addr.size(), 0);

    // reset during the address phase
    f0 = fetches;
    spi_begin(1'b0);
    send(8'h03);
    send(8'h00);
    rst = 1'b1;
    wait_clk(1);
    check("midrst_do", flash_do, 1);
    check("midrst_en", mem_en, 0);
    check("midrst_addr", mem_addr, 0);
    rst = 1'b0;
    send(8'h03);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    exp_rx.push_back(8'hFF);
    rx_byte("midrst_miso");
    spi_end(1'b0);
    check("midrst_nofetch", fetches, f0);
    exp_rx.push_back(8'h00);
    spi_begin(1'b0);
    send(8'h05);
    rx_byte("post_rst_rdsr");
    spi_end(1'b0);

    check("fetch_left", exp_addr.size(), 0);
    check("rx_left", exp_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
